// File: rtl/cls_eval_pkg.sv
// cls_eval_pkg: shared state encoding and width helpers for the classifier evaluation sequencer
package cls_eval_pkg;
    typedef enum logic {S_IDLE, S_SETTLE} state_t;
    function automatic int in_w(input int num_a, input int width_a);
        return num_a * width_a;
    endfunction
    function automatic int cnt_w(input int settle);
        return $clog2(settle) + 1;
    endfunction
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int ent_w(input int tag_w, input int outwidth);
        return tag_w + outwidth;
    endfunction
endpackage

// File: rtl/cls_result_fifo.sv
// cls_result_fifo: first-word fall-through result buffer with wrap-bit pointers
module cls_result_fifo
    import cls_eval_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = ptr_w(DEPTH);
    logic [PTR_W:0]     r_wr;
    logic [PTR_W:0]     r_rd;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_pop;
    assign w_pop     = pop && !empty;
    assign empty     = r_wr == r_rd;
    assign full      = (r_wr[PTR_W] != r_rd[PTR_W]) && (r_wr[PTR_W-1:0] == r_rd[PTR_W-1:0]);
    assign count     = r_wr - r_rd;
    assign head_data = empty ? '0 : r_mem[r_rd[PTR_W-1:0]];
    // advance write/read pointers; a push and pop together leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (push) r_wr <= r_wr + (PTR_W+1)'(1);
            if (w_pop) r_rd <= r_rd + (PTR_W+1)'(1);
        end
    end
    // storage needs no reset because the head is masked to zero while empty
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr[PTR_W-1:0]] <= push_data;
    end
endmodule

// File: rtl/cls_eval_sequencer.sv
// cls_eval_sequencer: handshaked drive/settle/capture sequencer for a combinational classifier core
module cls_eval_sequencer
    import cls_eval_pkg::*;
#(
    parameter int WIDTH_A    = 4,
    parameter int NUM_A      = 11,
    parameter int OUTWIDTH   = 20,
    parameter int SETTLE     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_A*WIDTH_A-1:0]   in_data,
    output logic [NUM_A*WIDTH_A-1:0]   core_inp,
    input  logic [OUTWIDTH-1:0]        core_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OUTWIDTH-1:0]        res_data,
    output logic [TAG_W-1:0]           res_tag,
    output logic                       busy
);
    localparam int IN_W  = in_w(NUM_A, WIDTH_A);
    localparam int CNT_W = cnt_w(SETTLE);
    localparam int PTR_W = ptr_w(FIFO_DEPTH);
    localparam int ENT_W = ent_w(TAG_W, OUTWIDTH);
    localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [TAG_W-1:0]   r_tag;
    logic [IN_W-1:0]    r_inp;
    logic               w_acc;
    logic               w_cap;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic [PTR_W:0]     w_count;
    logic [ENT_W-1:0]   w_head;
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end
    // next state plus handshake and capture strobes; ready is held low while in reset
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        w_acc       = 1'b0;
        w_cap       = 1'b0;
        if (r_state == S_IDLE) begin
            in_ready    = rst_n && (w_count < DEPTH_C);
            w_acc       = in_valid && in_ready;
            w_state_nxt = w_acc ? S_SETTLE : S_IDLE;
        end else begin
            busy        = 1'b1;
            w_cap       = r_cnt == '0;
            w_state_nxt = w_cap ? S_IDLE : S_SETTLE;
        end
    end
    // latch the accepted vector onto the core, count down the settle time, bump the tag on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inp <= '0;
            r_cnt <= '0;
            r_tag <= '0;
        end else begin
            if (w_acc) begin
                r_inp <= in_data;
                r_cnt <= CNT_W'(SETTLE - 1);
            end else if (busy && !w_cap) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_cap) r_tag <= r_tag + TAG_W'(1);
        end
    end
    assign w_pop     = !w_empty && res_ready;
    assign res_valid = !w_empty;
    assign core_inp  = r_inp;
    assign {res_tag, res_data} = w_head;
    cls_result_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_cap),
        .push_data ({r_tag, core_out}),
        .pop       (w_pop),
        .head_data (w_head),
        .empty     (w_empty),
        .full      (w_full),
        .count     (w_count)
    );
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_cap && w_full));
endmodule

// File: tb/tb_cls_eval_sequencer.sv
// tb_cls_eval_sequencer: scoreboard bench driving a default sequencer and a 2-bit-tag twin in lockstep
module tb_cls_eval_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [43:0] in_data = '0;
    logic        in_ready, res_valid, busy;
    logic [43:0] core_inp;
    logic [19:0] core_out, res_data;
    logic [15:0] res_tag;
    logic        in_ready_w, res_valid_w, busy_w;
    logic [43:0] core_inp_w;
    logic [19:0] core_out_w, res_data_w;
    logic [1:0]  res_tag_w;
    int          n_chk = 0;
    int          n_err = 0;
    logic [35:0] q[$];
    logic [15:0] tag_m = '0;

    always #5 clk = ~clk;

    function automatic logic [19:0] fsum(input logic [43:0] v);
        logic [19:0] s = '0;
        for (int i = 0; i < 11; i++) s = s + 20'(v[i*4 +: 4]);
        return s;
    endfunction

    assign core_out   = fsum(core_inp);
    assign core_out_w = fsum(core_inp_w);

    cls_eval_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_inp(core_inp), .core_out(core_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .busy(busy)
    );

    cls_eval_sequencer #(.TAG_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .core_inp(core_inp_w), .core_out(core_out_w), .res_valid(res_valid_w), .res_ready(res_ready),
        .res_data(res_data_w), .res_tag(res_tag_w), .busy(busy_w)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        q.delete();
        tag_m = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] f);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data = {11{f}};
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) chk("send_timeout", 0, 1);
        else begin
            q.push_back({tag_m, 20'(f) * 20'd11});
            tag_m = tag_m + 16'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (q.size() == 0) break;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        @(negedge clk);
        chk("drain_empty", res_valid, 0);
    endtask

    always @(negedge clk) begin : monitor
        logic [35:0] e;
        #1;
        if (rst_n && res_valid && res_ready) begin
            if (q.size() == 0) chk("extra_result", 1, 0);
            else begin
                e = q.pop_front();
                chk("res_data", res_data, e[19:0]);
                chk("res_tag", res_tag, e[35:20]);
                chk("res_data_w", res_data_w, e[19:0]);
                chk("res_tag_w", res_tag_w, e[21:20]);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_res_valid", res_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_core_inp", core_inp, 0);
        chk("idle_res_tag", res_tag, 0);
        chk("idle_res_data", res_data, 0);

        res_ready = 1'b1;
        send(4'd3);
        chk("sv_core_inp", core_inp, 44'h33333333333);
        chk("sv_busy0", busy, 1);
        chk("sv_in_ready", in_ready, 0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("sv_busy", busy, 1);
            chk("sv_early_valid", res_valid, 0);
        end
        @(negedge clk);
        chk("sv_busy_end", busy, 0);
        chk("sv_res_valid", res_valid, 1);
        chk("sv_ready_again", in_ready, 1);
        drain();
        chk("sv_core_inp_hold", core_inp, 44'h33333333333);

        do_reset();
        res_ready = 1'b0;
        for (int f = 1; f <= 4; f++) send(4'(f));
        repeat (4) @(negedge clk);
        chk("bp_full_ready", in_ready, 0);
        chk("bp_count", dut.u_fifo.count, 4);
        in_valid = 1'b1;
        in_data = {11{4'd5}};
        repeat (3) @(negedge clk) chk("bp_hold", in_ready, 0);
        chk("bp_no_accept", core_inp, {11{4'd4}});
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp_ready_after_pop", in_ready, 1);
        send(4'd5);
        drain();

        do_reset();
        res_ready = 1'b0;
        send(4'd1);
        send(4'd2);
        repeat (4) @(negedge clk);
        chk("pp_count_pre", dut.u_fifo.count, 2);
        send(4'd6);
        repeat (3) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        chk("pp_count", dut.u_fifo.count, 2);
        chk("pp_valid", res_valid, 1);
        drain();

        do_reset();
        res_ready = 1'b0;
        for (int f = 1; f <= 4; f++) send(4'(f));
        @(negedge clk);
        chk("mr_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_res_valid", res_valid, 0);
        chk("mr_core_inp", core_inp, 0);
        chk("mr_busy", busy, 0);
        chk("mr_in_ready", in_ready, 0);
        chk("mr_res_tag", res_tag, 0);
        q.delete();
        tag_m = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mr_no_capture", res_valid, 0);
        chk("mr_count", dut.u_fifo.count, 0);
        res_ready = 1'b1;
        send(4'd7);
        drain();

        do_reset();
        res_ready = 1'b1;
        for (int f = 1; f <= 6; f++) send(4'(f));
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/cls_eval_sequencer.md
Name: cls_eval_sequencer

Overview:
Synthesizable stimulus/capture sequencer for a combinational printed-ML classifier core (e.g. the red-wine MLP, `top`).
- Accepts feature vectors over a valid/ready stream and drives them onto the core's packed input bus.
- Waits a parametrised settle time, captures the core output and buffers it with a sequence tag in a result FIFO.
- Sits between the on-chip input source (UART/ROM loader) and the result drain, replacing free-running sample-and-wait stimulus with a handshaked, backpressure-safe path.

Parameters:
WIDTH_A, 4, bits per input feature
NUM_A, 11, number of input features
OUTWIDTH, 20, classifier output width
SETTLE, 4, cycles the core input is held before capture (>=1)
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)
TAG_W, 16, sequence tag width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  sequencer can accept a vector
in_data  in  NUM_A*WIDTH_A  packed features; feature i at [(i+1)*WIDTH_A-1 : i*WIDTH_A]
core_inp  out  NUM_A*WIDTH_A  registered drive to classifier `inp`
core_out  in  OUTWIDTH  classifier `out`, combinational from core_inp
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer takes head
res_data  out  OUTWIDTH  captured classifier output at head
res_tag  out  TAG_W  sequence number of head entry
busy  out  1  high while a vector is settling

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, core_inp=0, settle counter=0, tag counter=0.
  - FIFO emptied; res_valid=0, res_data=0, res_tag=0 while empty; busy=0.
  - in_ready=0 during reset, 1 on the first cycle after release.
- Reset mid-operation discards the settling vector and all buffered results. No capture occurs for the discarded vector.
- FSM states:
  - IDLE: in_ready = (fifo_count < FIFO_DEPTH); busy=0.
    - Accept on rising edge t when in_valid && in_ready: core_inp <= in_data, cnt <= SETTLE-1, state <= SETTLE.
  - SETTLE: in_ready=0; busy=1; core_inp stable.
    - If cnt != 0: cnt decrements.
    - If cnt == 0, at that edge: push {tag, core_out} into FIFO, tag <= tag+1, state <= IDLE.
- Latency: accepted at edge t, captured at edge t+SETTLE, res_valid high from cycle after t+SETTLE if FIFO was empty.
- Throughput: at most one vector per SETTLE+1 cycles. A new accept is possible at edge t+SETTLE+1.
- core_inp holds its last value in IDLE (not cleared).
- Tag wraps modulo 2^TAG_W, from 2^TAG_W-1 to 0. The first vector after reset gets tag 0.
- FIFO behaviour:
  - First-word fall-through: res_valid = !empty; res_data and res_tag show the head combinationally from storage.
  - Pop on res_valid && res_ready.
- Overflow impossible by construction: accept requires a free slot, only one vector is in flight, and pops only free space. Push into a full FIFO is an assertion failure.
- Simultaneous push and pop in the same cycle: count unchanged, head advances, new entry is written.
- in_valid while in_ready=0: ignored. The source must hold data, standard valid/ready rules.
- in_data is sampled only on accept. Changes at other times have no effect.
- SETTLE=1: capture on the edge immediately following accept.

Decomposition:
- Shared package cls_eval_pkg:
  - FSM state encoding (IDLE, SETTLE).
  - Derived localparams: IN_W = NUM_A*WIDTH_A, CNT_W = clog2(SETTLE)+1, PTR_W = clog2(FIFO_DEPTH).
  - Result entry width TAG_W+OUTWIDTH.
- One sub-module, cls_result_fifo:
  - Parametrised synchronous FWFT FIFO (WIDTH, DEPTH), same clk/rst_n.
  - Ports: push, push_data, pop, head_data, empty, full, count.
  - Pointers use an extra wrap bit.

Test Plan:
(Core model in bench: core_out = sum of the 11 features, zero-extended. Defaults apply.)
- Reset/idle: hold rst_n=0 five cycles then release, no in_valid -> in_ready=1, res_valid=0, busy=0, core_inp=0, res_tag=0.
- Single vector: all features =3, res_ready=1, accept at edge t -> core_inp=0x33333333333 from t.
  - busy=1 for 4 cycles; res_valid rises after edge t+4.
  - res_data=33, res_tag=0.
- Backpressure fill: res_ready=0, send 5 vectors with features all 1, 2, 3, 4, 5 ->
  - First 4 captured (res_data 11, 22, 33, 44; tags 0..3).
  - in_ready=0 after the 4th capture; 5th held by source.
  - Raise res_ready for one cycle -> 5th accepted, later captured as 55 with tag 4.
- Concurrent push/pop: FIFO holds 2 entries, res_ready=1 continuously while a capture lands -> count stays 2 at that edge; no entry lost or duplicated; tags strictly consecutive.
- Mid-operation reset: assert rst_n=0 two cycles into SETTLE with 3 entries queued ->
  - res_valid=0 and core_inp=0 immediately (asynchronous).
  - After release the next vector gets tag 0.
  - No capture of the aborted vector.
- Tag wrap (TAG_W=2): stream 6 vectors with res_ready=1 -> tags 0, 1, 2, 3, 0, 1 in order.
